// File: rtl/reg_file_sb_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sb_if
// Description : Bundle of read, writeback, issue and flush signals for the
//               scoreboarded register file.
//               master : decode/issue/writeback side (drives ids, data, tags)
//               slave  : register file (returns read data, busy, busy count)
// Ports       : rd_id/rd_data/rd_busy per read port; wr_en/wr_id/wr_data/
//               wr_tag per writeback port; iss_en/iss_id/iss_tag; flush;
//               busy_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_sb_if #(
  parameter int REG_CNT  = 32,
  parameter int DATA_W   = 64,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 2,
  parameter int TAG_W    = 4
);
  localparam int CNT_W = $clog2(REG_CNT + 1);

  logic [7:0]        rd_id   [RD_PORTS];
  logic [DATA_W-1:0] rd_data [RD_PORTS];
  logic              rd_busy [RD_PORTS];

  logic              wr_en   [WR_PORTS];
  logic [7:0]        wr_id   [WR_PORTS];
  logic [DATA_W-1:0] wr_data [WR_PORTS];
  logic [TAG_W-1:0]  wr_tag  [WR_PORTS];

  logic              iss_en;
  logic [7:0]        iss_id;
  logic [TAG_W-1:0]  iss_tag;
  logic              flush;

  logic [CNT_W-1:0]  busy_cnt;

  modport master (
    output rd_id, wr_en, wr_id, wr_data, wr_tag, iss_en, iss_id, iss_tag, flush,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  rd_id, wr_en, wr_id, wr_data, wr_tag, iss_en, iss_id, iss_tag, flush,
    output rd_data, rd_busy, busy_cnt
  );
endinterface
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sb
// Description : Architectural register file with tagged issue/writeback
//               scoreboard, multi-port reads with same-cycle write bypass,
//               flush of all reservations and a registered busy count.
// Ports       : clk     - single clock, rising edge
//               reset_n - asynchronous active-low reset
//               bus     - reg_file_sb_if.slave (reads, writebacks, issue,
//                         flush, busy_cnt)
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
  parameter int              REG_CNT  = 32,
  parameter int              DATA_W   = 64,
  parameter int              RD_PORTS = 2,
  parameter int              WR_PORTS = 2,
  parameter int              TAG_W    = 4,
  parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
  input  wire logic     clk,
  input  wire logic     reset_n,
  reg_file_sb_if.slave  bus
);

  localparam int         IDX_W  = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;
  localparam int         CNT_W  = $clog2(REG_CNT + 1);
  localparam logic [8:0] ID_LIM = 9'(REG_CNT);
  localparam int         RSP_ID = 4;

  // Ids are 8 bits wide but only REG_CNT of them are implemented.
  function automatic logic id_ok(input logic [7:0] id);
    return {1'b0, id} < ID_LIM;
  endfunction

  function automatic logic [IDX_W-1:0] idx(input logic [7:0] id);
    return id[IDX_W-1:0];
  endfunction

  logic [DATA_W-1:0]  data_q [REG_CNT];
  logic [DATA_W-1:0]  data_d [REG_CNT];
  logic [TAG_W-1:0]   tag_q  [REG_CNT];
  logic [TAG_W-1:0]   tag_d  [REG_CNT];
  logic [REG_CNT-1:0] busy_q;
  logic [REG_CNT-1:0] busy_d;
  logic [REG_CNT-1:0] clr;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;

  // --------------------------------------------------------------------------
  // Next state. Busy-clear decisions use the pre-edge busy/tag so that a
  // same-cycle issue (applied afterwards) always wins over a writeback.
  // --------------------------------------------------------------------------
  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    clr    = '0;

    // Ascending port order: the highest-index writer to an id owns its data.
    for (int p = 0; p < WR_PORTS; p++) begin
      if (bus.wr_en[p] && id_ok(bus.wr_id[p])) begin
        data_d[idx(bus.wr_id[p])] = bus.wr_data[p];
        if (busy_q[idx(bus.wr_id[p])] && (tag_q[idx(bus.wr_id[p])] == bus.wr_tag[p])) begin
          clr[idx(bus.wr_id[p])] = 1'b1;
        end
      end
    end

    busy_d = busy_q & ~clr;

    // Flush suppresses a same-cycle issue completely, tag included.
    if (bus.flush) begin
      busy_d = '0;
    end else if (bus.iss_en && id_ok(bus.iss_id)) begin
      busy_d[idx(bus.iss_id)] = 1'b1;
      tag_d[idx(bus.iss_id)]  = bus.iss_tag;
    end

    cnt_d = '0;
    for (int i = 0; i < REG_CNT; i++) begin
      cnt_d = cnt_d + CNT_W'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_CNT; i++) begin
        data_q[i] <= (i == RSP_ID) ? RSP_INIT : '0;
        tag_q[i]  <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports: array value, overridden by same-cycle writebacks. Bypass is
  // held off during reset so reads show the reset image.
  // --------------------------------------------------------------------------
  for (genvar r = 0; r < RD_PORTS; r++) begin : g_rd
    logic [DATA_W-1:0] data_c;
    logic              busy_c;

    always_comb begin
      data_c = '0;
      busy_c = 1'b0;
      if (id_ok(bus.rd_id[r])) begin
        data_c = data_q[idx(bus.rd_id[r])];
        busy_c = busy_q[idx(bus.rd_id[r])];
        if (reset_n) begin
          for (int p = 0; p < WR_PORTS; p++) begin
            if (bus.wr_en[p] && (bus.wr_id[p] == bus.rd_id[r])) begin
              data_c = bus.wr_data[p];
              if (bus.wr_tag[p] == tag_q[idx(bus.rd_id[r])]) begin
                busy_c = 1'b0;
              end
            end
          end
        end
      end
    end

    assign bus.rd_data[r] = data_c;
    assign bus.rd_busy[r] = busy_c;
  end

  assign bus.busy_cnt = cnt_q;

endmodule
`default_nettype wire
